// File: rtl/mod_mul_arb.sv
// Round-robin front end that shares one modular multiplier among four requesters,
// with a per-operation timeout that returns an error response instead of a result.
//
// state | meaning
// IDLE  | no operation in flight; grants the next requester and latches its operands
// ISSUE | start pulse to the multiplier, ack to the winner
// WAIT  | waiting for mm_done or for the timeout to expire
// RESP  | rsp_valid pulse to the winner
module mod_mul_arb #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [3:0]    req,
    input  logic [1023:0] op_a,
    input  logic [1023:0] op_b,
    output logic [3:0]    ack,
    output logic [3:0]    rsp_valid,
    output logic [255:0]  rsp_data,
    output logic          rsp_err,
    output logic [255:0]  mm_a,
    output logic [255:0]  mm_b,
    output logic          mm_start,
    input  logic [255:0]  mm_c,
    input  logic          mm_done,
    output logic          busy
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_ISSUE = 4'b0010,
        S_WAIT  = 4'b0100,
        S_RESP  = 4'b1000
    } state_t;

    // Down-counter loaded in ISSUE; reaching zero in WAIT marks the TIMEOUT-th wait cycle.
    localparam logic [15:0] TC_LOAD = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  rr;
    logic [1:0]  winner;
    logic [1:0]  grant_idx;
    logic [1:0]  cand;
    logic        grant_found;
    logic [15:0] cnt;
    logic        tmo_hit;
    logic [3:0]  win_oh;

    assign tmo_hit = (cnt == 16'd0);
    assign win_oh  = 4'b0001 << winner;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr;
        cand        = rr;
        for (int i = 0; i < 4; i++) begin
            cand = rr + 2'(i);
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_found) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (mm_done || tmo_hit) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        mm_start  = (state == S_ISSUE);
        ack       = 4'b0000;
        rsp_valid = 4'b0000;
        if (state == S_ISSUE) ack = win_oh;
        if (state == S_RESP)  rsp_valid = win_oh;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr       <= 2'd0;
            winner   <= 2'd0;
            cnt      <= 16'd0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            mm_a     <= '0;
            mm_b     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        mm_a   <= op_a[{grant_idx, 8'h00} +: 256];
                        mm_b   <= op_b[{grant_idx, 8'h00} +: 256];
                        winner <= grant_idx;
                        rr     <= grant_idx + 2'd1;
                    end
                end
                S_ISSUE: cnt <= TC_LOAD;
                S_WAIT: begin
                    // A completion in the last wait cycle still wins over the timeout.
                    if (mm_done) begin
                        rsp_data <= mm_c;
                        rsp_err  <= 1'b0;
                    end else if (tmo_hit) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
